seg_scan_ctrl: RTL

Time-multiplexed scan controller for a multi-digit common-segment 7-segment display. It holds a packed BCD value and drives one digit nibble at a time into the shared `bcd_to_7_segment` decoder. It registers the decoded pattern and enables exactly one digit anode per slot, with a blanking gap between slots to prevent ghosting. It sits between the datapath producing a BCD result and the board-level display pins, and is the only user of the decoder instance.

---
 rtl/seg_scan_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-segment 7-segment display.
// Double-buffers a packed BCD value and drives one digit per slot through a shared decoder.
module seg_scan_ctrl #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 50000,
    parameter int unsigned BLANK  = 4,
    localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic                  lz_en_i,
    output logic [3:0]            bcd_out_o,
    input  logic [6:0]            seg_in_i,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     an_o,
    output logic [IdxW-1:0]       digit_idx_o,
    output logic                  frame_done_o
);

    localparam int unsigned CntW = $clog2(DIV);
    localparam logic [CntW-1:0] CntMax   = CntW'(DIV - 1);
    localparam logic [CntW-1:0] CntBlank = CntW'(BLANK);
    localparam logic [IdxW-1:0] IdxMax   = IdxW'(DIGITS - 1);

    typedef enum logic {StIdle, StScan} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0]   pending_q, pending_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic [3:0]            bcd_q, bcd_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;

    logic                  frame_start;
    logic                  suppress;
    logic [4*DIGITS-1:0]   upper_cur;
    logic [4*DIGITS-1:0]   upper_nxt;

    // A digit is blanked when it and every more-significant nibble are zero.
    assign upper_cur = shadow_q >> {idx_q, 2'b00};
    assign suppress  = lz_en_i && (idx_q != '0) && (upper_cur == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        pending_d   = pending_q;
        pend_vld_d  = pend_vld_q;
        shadow_d    = shadow_q;
        bcd_d       = bcd_q;
        an_d        = '0;
        seg_d       = '0;
        frame_start = 1'b0;
        upper_nxt   = '0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                if (en_i) begin
                    state_d     = StScan;
                    frame_start = 1'b1;
                end
            end
            StScan: begin
                if (!en_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    if (cnt_q == CntMax) begin
                        cnt_d = '0;
                        if (idx_q == IdxMax) begin
                            idx_d       = '0;
                            frame_start = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_q >= CntBlank && !suppress) begin
                        for (int i = 0; i < DIGITS; i++) begin
                            an_d[i] = (idx_q == IdxW'(i));
                        end
                        seg_d = seg_in_i;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Transfer reads the old pending value even if a load lands on the same edge.
        if (frame_start && pend_vld_q) begin
            shadow_d = pending_q;
        end
        if (load_i) begin
            pending_d  = value_i;
            pend_vld_d = 1'b1;
        end else if (frame_start) begin
            pend_vld_d = 1'b0;
        end

        if (state_d == StScan && cnt_d == '0) begin
            upper_nxt = shadow_d >> {idx_d, 2'b00};
            bcd_d     = upper_nxt[3:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            shadow_q   <= '0;
            bcd_q      <= '0;
            an_q       <= '0;
            seg_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            shadow_q   <= shadow_d;
            bcd_q      <= bcd_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign bcd_out_o    = bcd_q;
    assign seg_o        = seg_q;
    assign an_o         = an_q;
    assign digit_idx_o  = idx_q;
    assign frame_done_o = (state_q == StScan) && (idx_q == IdxMax) && (cnt_q == CntMax);

endmodule
